// File: rtl/noc_pkg.sv
// noc_pkg: shared packet layout and injector state encoding for the NoC injection port
package noc_pkg;
    localparam int PKT_W  = 39;
    localparam int DX_MSB = 38;
    localparam int DX_LSB = 35;
    localparam int DY_MSB = 34;
    localparam int DY_LSB = 31;
    localparam int PAY_W  = 31;

    typedef struct packed {
        logic [DX_MSB-DX_LSB:0] dest_x;
        logic [DY_MSB-DY_LSB:0] dest_y;
        logic [PAY_W-1:0]       payload;
    } noc_pkt_t;

    typedef enum logic [1:0] {IDLE, SETUP, REQ_HI, REQ_LO} inj_state_t;

    function automatic noc_pkt_t pack_pkt(input logic [DX_MSB-DX_LSB:0] x,
                                          input logic [DY_MSB-DY_LSB:0] y,
                                          input logic [PAY_W-1:0] p);
        return '{dest_x: x, dest_y: y, payload: p};
    endfunction
endpackage

// File: rtl/noc_sync_fifo.sv
// noc_sync_fifo: small power-of-two synchronous FIFO with registered occupancy count
module noc_sync_fifo
    import noc_pkg::*;
#(
    parameter int WIDTH = PKT_W,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
            count  <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/noc_pkt_injector.sv
// noc_pkt_injector: buffers valid/ready packets and drives them onto a 4-phase bundled-data NoC channel
module noc_pkt_injector
    import noc_pkg::*;
#(
    parameter int WIDTH       = PKT_W,
    parameter int DEPTH       = 4,
    parameter int SETUP_CYC   = 2,
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_dest_x,
    input  logic [3:0]         in_dest_y,
    input  logic [PAY_W-1:0]   in_payload,
    output logic               noc_req,
    output logic [WIDTH-1:0]   noc_data,
    input  logic               noc_ack,
    output logic               busy,
    output logic [CNT_W-1:0]   sent_cnt,
    output logic               timeout_err
);
    localparam int SW = $clog2(SETUP_CYC+1);
    localparam int TW = $clog2(TIMEOUT_CYC+1);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [SW-1:0] SETUP_LD = SW'(SETUP_CYC-1);
    localparam logic [TW-1:0] WAIT_MAX = TW'(TIMEOUT_CYC-1);

    inj_state_t       state;
    logic [SW-1:0]    setup_cnt;
    logic [TW-1:0]    wait_cnt;
    logic             run, ack_m, ack_s;
    logic             fifo_full, fifo_empty, pop;
    logic [CW-1:0]    fifo_count;
    logic [WIDTH-1:0] head, wdata;
    logic             waiting;

    assign wdata    = WIDTH'(pack_pkt(in_dest_x, in_dest_y, in_payload));
    assign in_ready = run && !fifo_full;
    assign pop      = state == IDLE && !fifo_empty;
    assign waiting  = state == REQ_HI || state == REQ_LO;
    assign busy     = state != IDLE || fifo_count != '0;

    noc_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid && in_ready),
        .pop   (pop),
        .wdata (wdata),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // run holds in_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run   <= 1'b0;
            ack_m <= 1'b0;
            ack_s <= 1'b0;
        end else begin
            run   <= 1'b1;
            ack_m <= noc_ack;
            ack_s <= ack_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            setup_cnt   <= '0;
            wait_cnt    <= '0;
            noc_req     <= 1'b0;
            noc_data    <= '0;
            sent_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (!fifo_empty) begin
                    noc_data  <= head;
                    setup_cnt <= SETUP_LD;
                    state     <= SETUP;
                end
                SETUP: if (setup_cnt == '0) begin
                    noc_req  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= REQ_HI;
                end else begin
                    setup_cnt <= setup_cnt - SW'(1);
                end
                REQ_HI: if (ack_s) begin
                    noc_req  <= 1'b0;
                    wait_cnt <= '0;
                    state    <= REQ_LO;
                end else if (wait_cnt != WAIT_MAX) begin
                    wait_cnt <= wait_cnt + TW'(1);
                end
                default: if (!ack_s) begin
                    sent_cnt <= sent_cnt + CNT_W'(1);
                    state    <= IDLE;
                end else if (wait_cnt != WAIT_MAX) begin
                    wait_cnt <= wait_cnt + TW'(1);
                end
            endcase
            // stale ack before a request is a protocol violation, flagged like a timeout
            if ((waiting && wait_cnt == WAIT_MAX) || (!waiting && ack_s)) timeout_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_noc_pkt_injector.sv
// tb_noc_pkt_injector: directed self-checking bench for the NoC packet injector
module tb_noc_pkt_injector;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_dest_x = '0;
    logic [3:0]  in_dest_y = '0;
    logic [30:0] in_payload = '0;
    logic        noc_req;
    logic [38:0] noc_data;
    logic        noc_ack;
    logic        busy;
    logic [2:0]  sent_cnt;
    logic        timeout_err;

    logic        auto_en = 1'b0, async_en = 1'b0, man_ack = 1'b0;
    logic        rsp_ack = 1'b0, tog_ack = 1'b0;
    int          rsp_dly = 0;
    int          tests = 0, fails = 0;
    int          rises = 0;
    logic        stab_bad = 1'b0;
    logic [38:0] prev_data = '0;
    logic        prev_req = 1'b0;
    logic [38:0] rx[$];
    logic [2:0]  exp_cnt = '0;

    noc_pkt_injector #(
        .WIDTH(39), .DEPTH(4), .SETUP_CYC(2), .TIMEOUT_CYC(16), .CNT_W(3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_dest_x   (in_dest_x),
        .in_dest_y   (in_dest_y),
        .in_payload  (in_payload),
        .noc_req     (noc_req),
        .noc_data    (noc_data),
        .noc_ack     (noc_ack),
        .busy        (busy),
        .sent_cnt    (sent_cnt),
        .timeout_err (timeout_err)
    );

    always #50 clk = ~clk;

    assign noc_ack = async_en ? tog_ack : rsp_ack;

    // clocked responder: follows req after 3 cycles, or mirrors man_ack
    always @(negedge clk) begin
        if (!auto_en) begin
            rsp_ack = man_ack;
            rsp_dly = 0;
        end else if (noc_req != rsp_ack) begin
            rsp_dly++;
            if (rsp_dly == 3) begin
                rsp_ack = noc_req;
                rsp_dly = 0;
            end
        end else begin
            rsp_dly = 0;
        end
    end

    // free-running receiver on a 73-unit clock unrelated to clk
    initial forever begin
        #36 if (async_en) tog_ack = noc_req;
        #37 if (async_en) tog_ack = noc_req;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if ((noc_req || noc_ack) && noc_data !== prev_data) stab_bad = 1'b1;
            if (noc_req && !prev_req) begin
                rises++;
                rx.push_back(noc_data);
            end
        end
        prev_data = noc_data;
        prev_req  = noc_req;
    end

    function automatic logic [38:0] mk(input int i);
        return {4'(i), 4'(7 - i), 31'(i * 16 + 5)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [38:0] p);
        int n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        chk("push_ready", in_ready, 1);
        {in_dest_x, in_dest_y, in_payload} = p;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 400) begin
            tick();
            n++;
        end
        chk(tag, n < 400, 1);
    endtask

    initial begin
        int base, r0, n;
        repeat (3) tick();
        chk("rst_ready", in_ready, 0);
        chk("rst_req", noc_req, 0);
        chk("rst_data", noc_data, 0);
        chk("rst_cnt", sent_cnt, 0);
        chk("rst_err", timeout_err, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_rst", in_ready, 1);

        auto_en = 1'b1;
        {in_dest_x, in_dest_y, in_payload} = {4'd1, 4'd2, 31'hABC};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t1_data_e0", noc_data, 0);
        chk("t1_busy_e0", busy, 1);
        tick();
        chk("t1_data_e1", noc_data, {4'd1, 4'd2, 31'hABC});
        chk("t1_req_e1", noc_req, 0);
        tick();
        chk("t1_req_e2", noc_req, 0);
        tick();
        chk("t1_req_e3", noc_req, 1);
        wait_idle("t1_done");
        exp_cnt++;
        chk("t1_cnt", sent_cnt, exp_cnt);
        chk("t1_busy", busy, 0);

        auto_en = 1'b0;
        base = rx.size();
        for (int i = 1; i <= 6; i++) begin
            {in_dest_x, in_dest_y, in_payload} = mk(i);
            in_valid = 1'b1;
            tick();
            chk("t2_ready", in_ready, i <= 4);
        end
        in_valid = 1'b0;
        chk("t2_req_stall", noc_req, 1);
        chk("t2_busy", busy, 1);
        auto_en = 1'b1;
        wait_idle("t2_done");
        repeat (5) tick();
        exp_cnt += 3'd5;
        chk("t2_cnt", sent_cnt, exp_cnt);
        chk("t2_rx_n", rx.size() - base, 5);
        for (int k = 0; k < 5; k++) chk("t2_order", rx[base + k], mk(k + 1));
        chk("t2_err", timeout_err, 0);

        auto_en = 1'b0;
        async_en = 1'b1;
        r0 = rises;
        for (int i = 10; i < 13; i++) push(mk(i));
        wait_idle("t3_done");
        exp_cnt += 3'd3;
        chk("t3_cnt", sent_cnt, exp_cnt);
        chk("t3_rises", rises - r0, 3);
        chk("t3_stable", stab_bad, 0);
        async_en = 1'b0;
        tick();

        push(mk(9));
        repeat (3) tick();
        chk("t4_req", noc_req, 1);
        repeat (15) tick();
        chk("t4_err_early", timeout_err, 0);
        tick();
        chk("t4_err", timeout_err, 1);
        chk("t4_req_hold", noc_req, 1);
        man_ack = 1'b1;
        n = 0;
        while (noc_req && n < 50) begin
            tick();
            n++;
        end
        chk("t4_ack_seen", noc_req, 0);
        man_ack = 1'b0;
        wait_idle("t4_done");
        exp_cnt++;
        chk("t4_cnt", sent_cnt, exp_cnt);
        chk("t4_err_sticky", timeout_err, 1);

        for (int i = 1; i <= 4; i++) push(mk(i));
        chk("t5_req", noc_req, 1);
        r0 = rises;
        rst_n = 1'b0;
        #1;
        chk("t5_req_rst", noc_req, 0);
        chk("t5_cnt_rst", sent_cnt, 0);
        chk("t5_err_rst", timeout_err, 0);
        chk("t5_ready_rst", in_ready, 0);
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        chk("t5_req_after", noc_req, 0);
        chk("t5_busy_after", busy, 0);
        chk("t5_no_req", rises - r0, 0);
        chk("t5_ready_after", in_ready, 1);
        exp_cnt = '0;

        auto_en = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            push(mk(i));
            wait_idle("t6_idle");
            exp_cnt++;
            chk("t6_cnt", sent_cnt, exp_cnt);
        end
        chk("t6_err", timeout_err, 0);

        auto_en = 1'b0;
        man_ack = 1'b1;
        repeat (4) tick();
        man_ack = 1'b0;
        repeat (3) tick();
        chk("t7_err", timeout_err, 1);
        chk("t7_req", noc_req, 0);
        chk("t7_cnt", sent_cnt, exp_cnt);
        chk("t7_busy", busy, 0);
        chk("final_stable", stab_bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
